// File: rtl/alu_cntl_if.sv
// Handshake bundle between instruction decode, the ALU control sequencer and the ALU.
// The master modport is the decode/ALU side and the slave modport is the sequencer.
interface alu_cntl_if #(
   parameter int OPCODE_W = 4,
   parameter int CNTL_W   = 3
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          alu_op;
   logic [OPCODE_W-1:0] opcode;
   logic                out_valid;
   logic                out_ready;
   logic [CNTL_W-1:0]   alu_cntl;
   logic                mc_busy;
   logic                illegal;

   modport master (
      output in_valid, alu_op, opcode, out_ready,
      input  in_ready, out_valid, alu_cntl, mc_busy, illegal
   );

   modport slave (
      input  in_valid, alu_op, opcode, out_ready,
      output in_ready, out_valid, alu_cntl, mc_busy, illegal
   );
endinterface

// File: rtl/alu_cntl_seq.sv
// Registered ALU control sequencer: decodes {alu_op, opcode} and holds the code for MC_LAT cycles on multi-cycle ops.
// Optional ALU_CNTL_ILLEGAL_EN: registers the illegal flag and forces illegal ops to be single-cycle.
//
// state | meaning
// IDLE  | no op held, ready to accept
// WAIT  | multi-cycle op occupying the ALU, cnt_q counting down
// VALID | alu_cntl final, waiting for out_ready
module alu_cntl_seq #(
   parameter int                   OPCODE_W = 4,
   parameter int                   CNTL_W   = 3,
   parameter int                   MC_LAT   = 4,
   parameter logic [2**CNTL_W-1:0] MC_MASK  = 8'b1100_0000
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_cntl_if.slave  bus
);
   localparam int CNT_W = $clog2(MC_LAT);

   typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNTL_W-1:0]  alu_cntl_q;
   logic               out_valid_q;
   logic               mc_busy_q;
   logic [CNTL_W-1:0]  code_d;
   logic               mc_d;
   logic               accept;
`ifdef ALU_CNTL_ILLEGAL_EN
   logic               ill_d;
   logic               illegal_q;
`endif

   always_comb begin
      code_d = '0;
`ifdef ALU_CNTL_ILLEGAL_EN
      ill_d  = 1'b0;
`endif
      case (bus.alu_op)
         2'b10: code_d = '0;
         2'b01: code_d = CNTL_W'(1);
         2'b00: begin
            if (int'(bus.opcode) >= 2 && int'(bus.opcode) <= (2**CNTL_W) + 1)
               code_d = CNTL_W'(bus.opcode - OPCODE_W'(2));
`ifdef ALU_CNTL_ILLEGAL_EN
            else
               ill_d = 1'b1;
`endif
         end
         default: begin
            code_d = '0;
`ifdef ALU_CNTL_ILLEGAL_EN
            ill_d  = 1'b1;
`endif
         end
      endcase
   end

`ifdef ALU_CNTL_ILLEGAL_EN
   assign mc_d = MC_MASK[code_d] & ~ill_d;
`else
   assign mc_d = MC_MASK[code_d];
`endif

   assign bus.in_ready  = (state_q == IDLE) || (state_q == VALID && bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.mc_busy   = mc_busy_q;
   assign bus.alu_cntl  = alu_cntl_q;
`ifdef ALU_CNTL_ILLEGAL_EN
   assign bus.illegal   = illegal_q;
`else
   assign bus.illegal   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_cntl_q  <= '0;
         out_valid_q <= 1'b0;
         mc_busy_q   <= 1'b0;
`ifdef ALU_CNTL_ILLEGAL_EN
         illegal_q   <= 1'b0;
`endif
      end else begin
         // An accept is possible from IDLE or from VALID with out_ready (back-to-back).
         if (accept) begin
            state_q     <= mc_d ? WAIT : VALID;
            cnt_q       <= mc_d ? CNT_W'(MC_LAT - 2) : '0;
            alu_cntl_q  <= code_d;
            out_valid_q <= ~mc_d;
            mc_busy_q   <= mc_d;
`ifdef ALU_CNTL_ILLEGAL_EN
            illegal_q   <= ill_d;
`endif
         end else begin
            case (state_q)
               WAIT: begin
                  if (cnt_q == '0) begin
                     state_q     <= VALID;
                     out_valid_q <= 1'b1;
                     mc_busy_q   <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               VALID: begin
                  if (bus.out_ready) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                  end
               end
               IDLE: ;
               default: begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  mc_busy_q   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_alu_cntl_seq.sv
// Directed self-checking bench for alu_cntl_seq with default parameters.
module tb_alu_cntl_seq;
   localparam int MC_LAT = 4;
`ifdef ALU_CNTL_ILLEGAL_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_cntl_if #(.OPCODE_W(4), .CNTL_W(3)) bus ();

   alu_cntl_seq #(
      .OPCODE_W(4), .CNTL_W(3), .MC_LAT(MC_LAT), .MC_MASK(8'b1100_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op (in_valid for exactly one accepting edge) and follow it to VALID.
   task automatic run_op(input logic [1:0] op, input logic [3:0] opc,
                         input logic [2:0] exp_code, input bit exp_mc, input logic exp_ill,
                         input string tag);
      chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.opcode   = opc;
      tick();
      bus.in_valid = 1'b0;
      if (exp_mc) begin
         for (int c = 1; c < MC_LAT; c++) begin
            chk({tag, " mc_busy in WAIT"},   32'(bus.mc_busy),   32'd1);
            chk({tag, " out_valid in WAIT"}, 32'(bus.out_valid), 32'd0);
            chk({tag, " in_ready in WAIT"},  32'(bus.in_ready),  32'd0);
            tick();
         end
      end
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " mc_busy"},   32'(bus.mc_busy),   32'd0);
      chk({tag, " alu_cntl"},  32'(bus.alu_cntl),  32'(exp_code));
      chk({tag, " illegal"},   32'(bus.illegal),   32'(exp_ill));
   endtask

   logic [1:0] b2b_op  [8];
   logic [3:0] b2b_opc [8];
   logic [2:0] b2b_exp [8];

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_op    = 2'b00;
      bus.opcode    = '0;
      bus.out_ready = 1'b1;
      tick();
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset alu_cntl",  32'(bus.alu_cntl),  32'd0);
      chk("reset mc_busy",   32'(bus.mc_busy),   32'd0);
      chk("reset illegal",   32'(bus.illegal),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

      // Decode sweep over alu_op=00; codes 6 and 7 are multi-cycle under the default mask.
      run_op(2'b00, 4'd2, 3'd0, 0, 1'b0, "op2");
      run_op(2'b00, 4'd3, 3'd1, 0, 1'b0, "op3");
      run_op(2'b00, 4'd4, 3'd2, 0, 1'b0, "op4");
      run_op(2'b00, 4'd5, 3'd3, 0, 1'b0, "op5");
      run_op(2'b00, 4'd6, 3'd4, 0, 1'b0, "op6");
      run_op(2'b00, 4'd7, 3'd5, 0, 1'b0, "op7");
      run_op(2'b00, 4'd8, 3'd6, 1, 1'b0, "op8 mc");
      run_op(2'b00, 4'd9, 3'd7, 1, 1'b0, "op9 mc");
      run_op(2'b10, 4'd7, 3'd0, 0, 1'b0, "add class");
      run_op(2'b01, 4'd7, 3'd1, 0, 1'b0, "sub class");
      run_op(2'b00, 4'hF, 3'd0, 0, ILL_EXP, "illegal opcode");
      run_op(2'b11, 4'd5, 3'd0, 0, ILL_EXP, "illegal class");
      run_op(2'b00, 4'd4, 3'd2, 0, 1'b0, "legal after illegal");

      // Back-pressure: hold a code-3 result, ignore a competing op, then release with a new op.
      tick();
      chk("idle out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.alu_op    = 2'b00;
      bus.opcode    = 4'd5;
      tick();
      bus.opcode    = 4'd9;
      for (int c = 0; c < 5; c++) begin
         chk("bp out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp alu_cntl",  32'(bus.alu_cntl),  32'd3);
         chk("bp in_ready",  32'(bus.in_ready),  32'd0);
         chk("bp mc_busy",   32'(bus.mc_busy),   32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      bus.opcode    = 4'd3;
      #1;
      chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk("bp release alu_cntl",  32'(bus.alu_cntl),  32'd1);
      chk("bp release out_valid", 32'(bus.out_valid), 32'd1);

      // Eight back-to-back single-cycle ops, one result per cycle.
      b2b_op  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
      b2b_opc = '{4'd7,  4'd2,  4'd5,  4'd3,  4'd6,  4'd0,  4'd4,  4'd3};
      b2b_exp = '{3'd5,  3'd0,  3'd3,  3'd0,  3'd4,  3'd1,  3'd2,  3'd1};
      for (int k = 0; k < 8; k++) begin
         bus.in_valid = 1'b1;
         bus.alu_op   = b2b_op[k];
         bus.opcode   = b2b_opc[k];
         tick();
         chk($sformatf("b2b[%0d] out_valid", k), 32'(bus.out_valid), 32'd1);
         chk($sformatf("b2b[%0d] alu_cntl", k),  32'(bus.alu_cntl),  32'(b2b_exp[k]));
      end
      bus.in_valid = 1'b0;
      tick();

      // Reset asserted in the middle of a multi-cycle op.
      bus.in_valid = 1'b1;
      bus.alu_op   = 2'b00;
      bus.opcode   = 4'd8;
      tick();
      bus.in_valid = 1'b0;
      chk("pre-reset mc_busy", 32'(bus.mc_busy), 32'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid-wait reset mc_busy",   32'(bus.mc_busy),   32'd0);
      chk("mid-wait reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid-wait reset alu_cntl",  32'(bus.alu_cntl),  32'd0);
      chk("mid-wait reset illegal",   32'(bus.illegal),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("after release in_ready",  32'(bus.in_ready),  32'd1);
      chk("after release out_valid", 32'(bus.out_valid), 32'd0);
      run_op(2'b00, 4'd5, 3'd3, 0, 1'b0, "after reset op");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
